// File: rtl/ifetch_fq_if.sv
// ifetch_fq_if: icache/predictor/redirect/decode bundle of the fetch stage.
interface ifetch_fq_if #(
  parameter int PC_BITS    = 32,
  parameter int INSTR_BITS = 32,
  parameter int FQ_DEPTH   = 4
);
  logic [PC_BITS-1:0]         current_pc;
  logic                       hit_cache;
  logic                       is_half;
  logic [INSTR_BITS-1:0]      instruction_in;
  logic [PC_BITS-1:0]         pred_next_pc;
  logic                       pred_taken;
  logic                       must_flush;
  logic [PC_BITS-1:0]         correct_address;
  logic                       invalid_prediction;
  logic                       invalid_instruction;
  logic [PC_BITS-1:0]         old_pc;
  logic [2*PC_BITS-1:0]       data_out;
  logic                       taken_branch;
  logic                       valid_o;
  logic                       ready_in;
  logic [$clog2(FQ_DEPTH):0]  fq_count;
  modport master (
    output current_pc, data_out, taken_branch, valid_o, fq_count,
    input  hit_cache, is_half, instruction_in, pred_next_pc, pred_taken, must_flush,
           correct_address, invalid_prediction, invalid_instruction, old_pc, ready_in
  );
  modport slave (
    input  current_pc, data_out, taken_branch, valid_o, fq_count,
    output hit_cache, is_half, instruction_in, pred_next_pc, pred_taken, must_flush,
           correct_address, invalid_prediction, invalid_instruction, old_pc, ready_in
  );
endinterface

// File: rtl/ifetch_fq.sv
// ifetch_fq: fetch PC generation, half-instruction assembly, miss-time redirect latch and fetch queue.
// Define IFQ_BYPASS_EN to forward a push straight to decode when the queue is empty.
module ifetch_fq #(
  parameter int                 PC_BITS    = 32,
  parameter int                 INSTR_BITS = 32,
  parameter int                 FQ_DEPTH   = 4,
  parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
  input logic        clk,
  input logic        rst_n,
  ifetch_fq_if.master bus
);
  localparam int HB = INSTR_BITS / 2;
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, WAIT} half_e;
  typedef enum logic [1:0] {NONE, LOW, HIGH} pend_e;
  logic [PC_BITS-1:0]    pc_q, pc_d, hnx_q, hnx_d, ptgt_q, ptgt_d, push_pc;
  logic [HB-1:0]         hlow_q, hlow_d;
  logic                  htk_q, htk_d, push_tk;
  logic [INSTR_BITS-1:0] push_ins;
  half_e                 half_q, half_d;
  pend_e                 pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PC_BITS-1:0]    mem_pc [FQ_DEPTH];
  logic [INSTR_BITS-1:0] mem_ins [FQ_DEPTH];
  logic                  mem_tk [FQ_DEPTH];
  logic                  redir, fetch_en, push, pop, st, byp;
  assign redir    = bus.must_flush | bus.invalid_prediction | bus.invalid_instruction;
  assign fetch_en = (cnt_q != CW'(FQ_DEPTH)) & ~redir & (pend_q == NONE);
  always_comb begin
    pc_d     = pc_q;
    half_d   = half_q;
    hlow_d   = hlow_q;
    htk_d    = htk_q;
    hnx_d    = hnx_q;
    pend_d   = pend_q;
    ptgt_d   = ptgt_q;
    push     = 1'b0;
    push_pc  = pc_q;
    push_ins = bus.instruction_in;
    push_tk  = bus.pred_taken;
    if (bus.hit_cache && (redir || pend_q != NONE)) begin
      pc_d   = bus.must_flush ? bus.correct_address : (pend_q != NONE) ? ptgt_q : bus.old_pc;
      pend_d = NONE;
      half_d = IDLE;
    end else if (redir) begin
      half_d = IDLE;
      if (bus.must_flush) begin
        pend_d = HIGH;
        ptgt_d = bus.correct_address;
      end else if (pend_q == NONE) begin
        pend_d = LOW;
        ptgt_d = bus.old_pc;
      end
    end else if (bus.hit_cache && fetch_en) begin
      if (half_q == WAIT) begin
        push     = 1'b1;
        push_pc  = pc_q - PC_BITS'(2);
        push_ins = {bus.instruction_in[HB-1:0], hlow_q};
        push_tk  = htk_q;
        pc_d     = hnx_q;
        half_d   = IDLE;
      end else if (bus.is_half) begin
        hlow_d = bus.instruction_in[HB-1:0];
        htk_d  = bus.pred_taken;
        hnx_d  = bus.pred_next_pc;
        pc_d   = pc_q + PC_BITS'(2);
        half_d = WAIT;
      end else begin
        push = 1'b1;
        pc_d = bus.pred_next_pc;
      end
    end
  end
`ifdef IFQ_BYPASS_EN
  assign byp = push & (cnt_q == '0) & bus.ready_in;
`else
  assign byp = 1'b0;
`endif
  // A redirect voids any pop in the same cycle along with the queue contents.
  assign pop    = (cnt_q != '0) & bus.ready_in & ~redir;
  assign st     = push & ~byp;
  assign cnt_d  = redir ? '0 : cnt_q + CW'(st) - CW'(pop);
  assign wptr_d = redir ? '0 : wptr_q + AW'(st);
  assign rptr_d = redir ? '0 : rptr_q + AW'(pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      half_q <= IDLE;
      hlow_q <= '0;
      htk_q  <= 1'b0;
      hnx_q  <= '0;
      pend_q <= NONE;
      ptgt_q <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      pc_q   <= pc_d;
      half_q <= half_d;
      hlow_q <= hlow_d;
      htk_q  <= htk_d;
      hnx_q  <= hnx_d;
      pend_q <= pend_d;
      ptgt_q <= ptgt_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (st) begin
      mem_pc[wptr_q]  <= push_pc;
      mem_ins[wptr_q] <= push_ins;
      mem_tk[wptr_q]  <= push_tk;
    end
  end
  assign bus.current_pc   = pc_q;
  assign bus.fq_count     = cnt_q;
  assign bus.valid_o      = (cnt_q != '0) | byp;
  assign bus.data_out     = byp ? {push_pc, push_ins} : {mem_pc[rptr_q], mem_ins[rptr_q]};
  assign bus.taken_branch = byp ? push_tk : mem_tk[rptr_q];
endmodule

// File: tb/tb_ifetch_fq.sv
// tb_ifetch_fq: directed scenarios plus randomized traffic checked against a queue-based fetch model.
module tb_ifetch_fq;
  localparam int PB = 32, IB = 32, D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ifetch_fq_if #(.PC_BITS(PB), .INSTR_BITS(IB), .FQ_DEPTH(D)) bus();
  ifetch_fq #(.PC_BITS(PB), .INSTR_BITS(IB), .FQ_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {logic [PB-1:0] pc; logic [IB-1:0] ins; logic tk;} ent_t;
  ent_t mq[$];
  logic [PB-1:0] m_pc, m_hnx, m_ptgt;
  logic [15:0]   m_hlow;
  logic          m_htk, m_half;
  int            m_pend;
  int total = 0, bad = 0;

  task automatic idle();
    bus.hit_cache = 0; bus.is_half = 0; bus.instruction_in = '0; bus.pred_next_pc = '0;
    bus.pred_taken = 0; bus.must_flush = 0; bus.correct_address = '0;
    bus.invalid_prediction = 0; bus.invalid_instruction = 0; bus.old_pc = '0; bus.ready_in = 0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic cycle();
    bit redir, push, pend_any;
    int n0;
    ent_t e, dummy;
    redir = bus.must_flush | bus.invalid_prediction | bus.invalid_instruction;
    n0 = mq.size();
    push = 0;
    pend_any = (m_pend != 0);
    if (bus.hit_cache && (redir || pend_any)) begin
      m_pc = bus.must_flush ? bus.correct_address : pend_any ? m_ptgt : bus.old_pc;
      m_pend = 0; m_half = 0;
    end else if (redir) begin
      m_half = 0;
      if (bus.must_flush) begin m_pend = 2; m_ptgt = bus.correct_address; end
      else if (!pend_any) begin m_pend = 1; m_ptgt = bus.old_pc; end
    end else if (bus.hit_cache && n0 < D) begin
      if (m_half) begin
        e.pc = m_pc - 2; e.ins = {bus.instruction_in[15:0], m_hlow}; e.tk = m_htk;
        push = 1; m_pc = m_hnx; m_half = 0;
      end else if (bus.is_half) begin
        m_hlow = bus.instruction_in[15:0]; m_htk = bus.pred_taken; m_hnx = bus.pred_next_pc;
        m_pc = m_pc + 2; m_half = 1;
      end else begin
        e.pc = m_pc; e.ins = bus.instruction_in; e.tk = bus.pred_taken;
        push = 1; m_pc = bus.pred_next_pc;
      end
    end
    if (redir) mq.delete();
    else begin
      if (bus.ready_in && n0 > 0) dummy = mq.pop_front();
`ifdef IFQ_BYPASS_EN
      if (push && n0 == 0 && bus.ready_in) push = 0;
`endif
      if (push) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_pc = '0; m_half = 0; m_pend = 0; m_hlow = '0; m_htk = 0; m_hnx = '0; m_ptgt = '0;
    total++; if (bus.current_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.current_pc); end
    total++; if (bus.fq_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.fq_count); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.hit_cache = 1; bus.pred_next_pc = m_pc + 4; bus.instruction_in = $urandom;
      cycle();
      total++;
      if (bus.current_pc !== PB'((i < 3 ? i + 1 : 4) * 4)) begin
        bad++; $display("FAIL fill_pc[%0d] got=%h exp=%h", i, bus.current_pc, (i < 3 ? i + 1 : 4) * 4);
      end
      total++;
      if (bus.fq_count !== 3'((i < 3 ? i + 1 : 4)) || bus.valid_o !== 1'b1) begin
        bad++; $display("FAIL fill_count[%0d] got=%0d/%b exp=%0d/1", i, bus.fq_count, bus.valid_o, (i < 3 ? i + 1 : 4));
      end
    end
    idle();
    bus.ready_in = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.valid_o !== 1'b1 || bus.data_out[63:32] !== PB'(4 * i)) begin
        bad++; $display("FAIL drain_head[%0d] got=%h/%b exp=%h/1", i, bus.data_out[63:32], bus.valid_o, 4 * i);
      end
      cycle();
    end
    total++; if (bus.fq_count !== 3'd0 || bus.valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%b exp=0/0", bus.fq_count, bus.valid_o); end
  endtask

  task automatic test_half();
    idle();
    bus.hit_cache = 1; bus.must_flush = 1; bus.correct_address = 32'h1E;
    cycle();
    total++; if (bus.current_pc !== 32'h1E) begin bad++; $display("FAIL half_setup_pc got=%h exp=1e", bus.current_pc); end
    idle();
    bus.hit_cache = 1; bus.is_half = 1; bus.instruction_in = 32'h1234AAAA; bus.pred_next_pc = 32'h300; bus.pred_taken = 1;
    cycle();
    total++; if (bus.current_pc !== 32'h20 || bus.fq_count !== 3'd0) begin bad++; $display("FAIL half_first got=%h/%0d exp=20/0", bus.current_pc, bus.fq_count); end
    idle();
    bus.hit_cache = 1; bus.instruction_in = 32'h5678BBBB; bus.pred_next_pc = 32'h999;
    cycle();
    total++; if (bus.current_pc !== 32'h300 || bus.fq_count !== 3'd1) begin bad++; $display("FAIL half_second got=%h/%0d exp=300/1", bus.current_pc, bus.fq_count); end
    total++;
    if (bus.data_out !== 64'h0000001E_BBBBAAAA || bus.taken_branch !== 1'b1) begin
      bad++; $display("FAIL half_entry got=%h/%b exp=0000001ebbbbaaaa/1", bus.data_out, bus.taken_branch);
    end
    idle();
    bus.ready_in = 1;
    cycle();
    idle();
  endtask

  task automatic test_pending_priority();
    idle();
    bus.invalid_prediction = 1; bus.old_pc = 32'h100;
    cycle();
    idle();
    bus.must_flush = 1; bus.correct_address = 32'h200;
    cycle();
    total++; if (bus.current_pc !== 32'h300) begin bad++; $display("FAIL pend_hold_pc got=%h exp=300", bus.current_pc); end
    idle();
    bus.hit_cache = 1; bus.pred_next_pc = 32'h777; bus.instruction_in = 32'hDEADBEEF;
    cycle();
    total++; if (bus.current_pc !== 32'h200 || bus.fq_count !== 3'd0) begin bad++; $display("FAIL pend_high got=%h/%0d exp=200/0", bus.current_pc, bus.fq_count); end
    idle();
    bus.invalid_instruction = 1; bus.old_pc = 32'h40;
    cycle();
    idle();
    bus.invalid_prediction = 1; bus.old_pc = 32'h80;
    cycle();
    idle();
    bus.hit_cache = 1; bus.pred_next_pc = 32'h777;
    cycle();
    total++; if (bus.current_pc !== 32'h40 || bus.fq_count !== 3'd0) begin bad++; $display("FAIL pend_keep got=%h/%0d exp=40/0", bus.current_pc, bus.fq_count); end
    idle();
  endtask

  task automatic test_flush_pop();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.hit_cache = 1; bus.pred_next_pc = m_pc + 4; bus.instruction_in = $urandom;
      cycle();
    end
    total++; if (bus.fq_count !== 3'd3) begin bad++; $display("FAIL flush_fill got=%0d exp=3", bus.fq_count); end
    idle();
    bus.ready_in = 1; bus.must_flush = 1; bus.hit_cache = 1; bus.correct_address = 32'h500;
    cycle();
    total++;
    if (bus.fq_count !== 3'd0 || bus.valid_o !== 1'b0 || bus.current_pc !== 32'h500) begin
      bad++; $display("FAIL flush_pop got=%0d/%b/%h exp=0/0/500", bus.fq_count, bus.valid_o, bus.current_pc);
    end
    idle();
  endtask

`ifdef IFQ_BYPASS_EN
  task automatic test_bypass();
    idle();
    bus.hit_cache = 1; bus.must_flush = 1; bus.correct_address = 32'h50;
    cycle();
    idle();
    bus.hit_cache = 1; bus.ready_in = 1; bus.instruction_in = 32'hCAFEF00D; bus.pred_next_pc = 32'h54;
    #1;
    total++;
    if (bus.valid_o !== 1'b1 || bus.data_out !== 64'h00000050_CAFEF00D) begin
      bad++; $display("FAIL bypass_same got=%b/%h exp=1/00000050cafef00d", bus.valid_o, bus.data_out);
    end
    cycle();
    total++; if (bus.fq_count !== 3'd0 || bus.current_pc !== 32'h54) begin bad++; $display("FAIL bypass_after got=%0d/%h exp=0/54", bus.fq_count, bus.current_pc); end
    idle();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.hit_cache = ($urandom_range(0, 9) < 7);
      bus.is_half = ($urandom_range(0, 3) == 0);
      bus.instruction_in = $urandom;
      bus.pred_next_pc = $urandom_range(0, 255) * 2;
      bus.pred_taken = $urandom_range(0, 1);
      bus.ready_in = ($urandom_range(0, 1) == 1);
      bus.must_flush = ($urandom_range(0, 24) == 0);
      bus.invalid_prediction = ($urandom_range(0, 24) == 0);
      bus.invalid_instruction = ($urandom_range(0, 24) == 0);
      bus.correct_address = $urandom_range(0, 255) * 2;
      bus.old_pc = $urandom_range(0, 255) * 2;
      cycle();
      total++; if (bus.current_pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, bus.current_pc, m_pc); end
      total++; if (bus.fq_count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, bus.fq_count, mq.size()); end
      if (mq.size() > 0) begin
        total++;
        if (bus.valid_o !== 1'b1 || bus.data_out !== {mq[0].pc, mq[0].ins} || bus.taken_branch !== mq[0].tk) begin
          bad++; $display("FAIL rnd_head[%0d] got=%b/%h/%b exp=1/%h%h/%b", n, bus.valid_o, bus.data_out, bus.taken_branch, mq[0].pc, mq[0].ins, mq[0].tk);
        end
      end
`ifndef IFQ_BYPASS_EN
      else begin
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=0", n, bus.valid_o); end
      end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_half();
    test_pending_priority();
    test_flush_pop();
`ifdef IFQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
